// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder: word geometry and
// the write-buffer entry layout.
package data_mem_responder_pkg;
  localparam int WORD_W   = 32;
  localparam int BYTE_OFF = 2;
  localparam int INDEX_W  = WORD_W - BYTE_OFF;

  typedef logic [INDEX_W-1:0] index_t;

  typedef struct packed {
    index_t              index;
    logic [WORD_W-1:0]   data;
  } wb_entry_t;

  function automatic logic misaligned(input logic [WORD_W-1:0] addr);
    return addr[BYTE_OFF-1:0] != '0;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// Processor fetch/data bus plus host preload port between a processor-side
// master and the memory responder.
interface data_mem_responder_if #(parameter int ADDR_W = 10);
  import data_mem_responder_pkg::*;

  logic [WORD_W-1:0] inst_addr;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] data_addr;
  logic [WORD_W-1:0] data_out;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] data_in;
  // Preload handshake: a word transfers on a rising clk edge where load_valid
  // and load_ready are both high; load_ready never depends on load_valid.
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [WORD_W-1:0] load_data;
  logic              load_ready;

  modport master (
    output inst_addr, data_addr, data_out, mem_read, mem_write,
           load_valid, load_addr, load_data,
    input  instr, data_in, load_ready
  );

  modport slave (
    input  inst_addr, data_addr, data_out, mem_read, mem_write,
           load_valid, load_addr, load_data,
    output instr, data_in, load_ready
  );
endinterface

// File: rtl/data_mem_responder_write_buffer.sv
// Circular store buffer with two combinational lookup ports; on multiple hits
// the youngest matching entry supplies the data.
module data_mem_responder_write_buffer
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output wb_entry_t              head_entry,
  output logic [$clog2(DEPTH):0] count,
  input  index_t                 a_index,
  output logic                   a_hit,
  output logic [WORD_W-1:0]      a_data,
  input  index_t                 b_index,
  output logic                   b_hit,
  output logic [WORD_W-1:0]      b_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  wb_entry_t entries [DEPTH];
  ptr_t      head_ptr;
  ptr_t      tail_ptr;
  ptr_t      slot;

  assign full       = count == CNT_W'(DEPTH);
  assign empty      = count == '0;
  assign head_entry = entries[head_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + ptr_t'(1);
      if (pop)  head_ptr <= head_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Push while full is only legal together with pop; the slot being written is
  // the head slot, whose old value has already been handed to the store.
  always_ff @(posedge clk) begin
    if (push) entries[tail_ptr] <= push_entry;
  end

  // Walk oldest to youngest so a later hit overrides an earlier one.
  always_comb begin
    a_hit  = 1'b0;
    a_data = '0;
    b_hit  = 1'b0;
    b_data = '0;
    slot   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_ptr + k[PTR_W-1:0];
      if (CNT_W'(k) < count) begin
        if (entries[slot].index == a_index) begin
          a_hit  = 1'b1;
          a_data = entries[slot].data;
        end
        if (entries[slot].index == b_index) begin
          b_hit  = 1'b1;
          b_data = entries[slot].data;
        end
      end
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word store with forwarding reads, posted stores via a
// write buffer, host preload port and sticky access-error flags.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  data_mem_responder_if.slave       bus,
  output logic                      err_misalign,
  output logic                      err_rw,
  output logic [$clog2(WB_DEPTH):0] wb_count
);
  logic [WORD_W-1:0] store [2**ADDR_W];

  logic [ADDR_W-1:0] data_idx;
  logic [ADDR_W-1:0] inst_idx;
  index_t            data_key;
  index_t            inst_key;
  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  logic              wb_full;
  logic              wb_empty;
  logic              pop;
  logic              load_fire;
  logic              a_hit;
  logic              b_hit;
  logic [WORD_W-1:0] a_data;
  logic [WORD_W-1:0] b_data;
  logic              unused_ok;

  assign data_idx   = bus.data_addr[ADDR_W+BYTE_OFF-1:BYTE_OFF];
  assign inst_idx   = bus.inst_addr[ADDR_W+BYTE_OFF-1:BYTE_OFF];
  assign data_key   = {{(INDEX_W-ADDR_W){1'b0}}, data_idx};
  assign inst_key   = {{(INDEX_W-ADDR_W){1'b0}}, inst_idx};
  assign push_entry = '{index: data_key, data: bus.data_out};

  // Full buffer always owns the write port; otherwise the loader wins over drain.
  assign pop            = wb_full | (!bus.load_valid & !wb_empty);
  assign load_fire      = bus.load_valid & !wb_full;
  assign bus.load_ready = !wb_full;

  data_mem_responder_write_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.mem_write),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (wb_full),
    .empty      (wb_empty),
    .head_entry (head_entry),
    .count      (wb_count),
    .a_index    (data_key),
    .a_hit      (a_hit),
    .a_data     (a_data),
    .b_index    (inst_key),
    .b_hit      (b_hit),
    .b_data     (b_data)
  );

  always_ff @(posedge clk) begin
    if (pop)            store[head_entry.index[ADDR_W-1:0]] <= head_entry.data;
    else if (load_fire) store[bus.load_addr]                 <= bus.load_data;
  end

  assign bus.instr   = b_hit ? b_data : store[inst_idx];
  assign bus.data_in = !bus.mem_read ? '0 : (a_hit ? a_data : store[data_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_misalign <= 1'b0;
      err_rw       <= 1'b0;
    end else begin
      if (misaligned(bus.inst_addr) ||
          ((bus.mem_read || bus.mem_write) && misaligned(bus.data_addr)))
        err_misalign <= 1'b1;
      if (bus.mem_read && bus.mem_write)
        err_rw <= 1'b1;
    end
  end

  assign unused_ok = ^{bus.data_addr[WORD_W-1:ADDR_W+BYTE_OFF],
                       bus.inst_addr[WORD_W-1:ADDR_W+BYTE_OFF],
                       head_entry.index[INDEX_W-1:ADDR_W]};
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scenario bench for data_mem_responder.
module tb_data_mem_responder;
  localparam int ADDR_W = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       err_misalign;
  logic       err_rw;
  logic [2:0] wb_count;
  int         checks = 0;
  int         errors = 0;

  data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .err_misalign (err_misalign),
    .err_rw       (err_rw),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.inst_addr  = 32'h0;
    bus.data_addr  = 32'h0;
    bus.data_out   = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = 32'h0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (wb_count != 3'd0 && n < 20) begin
      @(negedge clk); drive_idle(); #1;
      n++;
    end
    checks++;
    if (wb_count !== 3'd0) begin errors++; $display("FAIL %s drain: count=%0d want 0", name, wb_count); end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wb_count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", wb_count); end
    checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", err_misalign); end
    checks++; if (err_rw !== 1'b0)       begin errors++; $display("FAIL reset_rw: got %b want 0", err_rw); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.load_ready); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_loader();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_idle();
      bus.load_valid = 1'b1; bus.load_addr = ADDR_W'(i); bus.load_data = 32'h11 * (i + 1);
      #1;
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL loader_ready[%0d]: got %b want 1", i, bus.load_ready); end
    end
    @(negedge clk); drive_idle(); bus.inst_addr = 32'h8; #1;
    checks++; if (bus.instr !== 32'h33) begin errors++; $display("FAIL loader_instr8: got %h want 00000033", bus.instr); end
    bus.inst_addr = 32'hC; #1;
    checks++; if (bus.instr !== 32'h44) begin errors++; $display("FAIL loader_instrC: got %h want 00000044", bus.instr); end
    bus.inst_addr = 32'h0; #1;
    checks++; if (bus.data_in !== 32'h0) begin errors++; $display("FAIL noread_zero: got %h want 0", bus.data_in); end
  endtask

  task automatic test_store_load();
    @(negedge clk); drive_idle();
    bus.mem_write = 1'b1; bus.data_addr = 32'h40; bus.data_out = 32'hDEADBEEF; #1;
    @(negedge clk); drive_idle(); bus.mem_read = 1'b1; bus.data_addr = 32'h40; #1;
    checks++; if (wb_count !== 3'd1) begin errors++; $display("FAIL st_ld_count: got %0d want 1", wb_count); end
    checks++; if (bus.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL st_ld_buffered: got %h want deadbeef", bus.data_in); end
    @(negedge clk); #1;
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL st_ld_drained_count: got %0d want 0", wb_count); end
    checks++; if (bus.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL st_ld_drained: got %h want deadbeef", bus.data_in); end
  endtask

  task automatic test_full_blocking();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_idle();
      bus.load_valid = 1'b1; bus.load_addr = 10'd100; bus.load_data = 32'hCAFE0000;
      bus.mem_write = 1'b1; bus.data_addr = 32'h80 + 4 * i; bus.data_out = 32'h1000 + i;
      #1;
      checks++; if (bus.load_ready !== (i < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, bus.load_ready, (i < 4)); end
      checks++; if (wb_count !== ((i < 4) ? 3'(i) : 3'd4)) begin errors++; $display("FAIL full_count[%0d]: got %0d", i, wb_count); end
    end
    @(negedge clk); bus.mem_write = 1'b0; #1;
    checks++; if (wb_count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d want 4", wb_count); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b want 0", bus.load_ready); end
    @(negedge clk); #1;
    checks++; if (wb_count !== 3'd3) begin errors++; $display("FAIL full_resume_count: got %0d want 3", wb_count); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL full_resume_ready: got %b want 1", bus.load_ready); end
    wait_drain("full");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_idle(); bus.mem_read = 1'b1; bus.data_addr = 32'h80 + 4 * i; #1;
      checks++; if (bus.data_in !== 32'h1000 + i) begin errors++; $display("FAIL full_read[%0d]: got %h want %h", i, bus.data_in, 32'h1000 + i); end
    end
    bus.data_addr = 32'h190; #1;
    checks++; if (bus.data_in !== 32'hCAFE0000) begin errors++; $display("FAIL full_loader_word: got %h want cafe0000", bus.data_in); end
  endtask

  task automatic test_overwrite();
    @(negedge clk); drive_idle();
    bus.load_valid = 1'b1; bus.load_addr = 10'd101; bus.load_data = 32'h0;
    bus.mem_write = 1'b1; bus.data_addr = 32'h10; bus.data_out = 32'h1; #1;
    @(negedge clk); bus.data_out = 32'h2; #1;
    @(negedge clk); bus.mem_write = 1'b0; bus.mem_read = 1'b1; #1;
    checks++; if (wb_count !== 3'd2) begin errors++; $display("FAIL ovw_count: got %0d want 2", wb_count); end
    checks++; if (bus.data_in !== 32'h2) begin errors++; $display("FAIL ovw_youngest: got %h want 2", bus.data_in); end
    wait_drain("ovw");
    bus.mem_read = 1'b1; bus.data_addr = 32'h10; #1;
    checks++; if (bus.data_in !== 32'h2) begin errors++; $display("FAIL ovw_store: got %h want 2", bus.data_in); end
  endtask

  task automatic test_loader_shadow();
    @(negedge clk); drive_idle();
    bus.load_valid = 1'b1; bus.load_addr = 10'd102; bus.load_data = 32'h0;
    bus.mem_write = 1'b1; bus.data_addr = 32'h20; bus.data_out = 32'h5; #1;
    @(negedge clk); bus.mem_write = 1'b0; bus.mem_read = 1'b1;
    bus.load_addr = 10'd8; bus.load_data = 32'h9; bus.inst_addr = 32'h20; #1;
    checks++; if (bus.instr !== 32'h5) begin errors++; $display("FAIL shadow_instr: got %h want 5", bus.instr); end
    @(negedge clk); bus.load_valid = 1'b0; #1;
    checks++; if (bus.data_in !== 32'h5) begin errors++; $display("FAIL shadow_buffered: got %h want 5", bus.data_in); end
    wait_drain("shadow");
    bus.mem_read = 1'b1; bus.data_addr = 32'h20; #1;
    checks++; if (bus.data_in !== 32'h5) begin errors++; $display("FAIL shadow_store: got %h want 5", bus.data_in); end
  endtask

  task automatic test_errors();
    @(negedge clk); drive_idle();
    bus.mem_write = 1'b1; bus.data_addr = 32'h44; bus.data_out = 32'h66; #1;
    wait_drain("err_prep");
    checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clean: got %b want 0", err_misalign); end
    @(negedge clk); drive_idle(); bus.mem_read = 1'b1; bus.data_addr = 32'h41; #1;
    checks++; if (bus.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_data: got %h want deadbeef", bus.data_in); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b want 1", err_misalign); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", err_misalign); end
    checks++; if (err_rw !== 1'b0) begin errors++; $display("FAIL rw_clean: got %b want 0", err_rw); end
    @(negedge clk); bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.data_addr = 32'h44; bus.data_out = 32'h77; #1;
    checks++; if (bus.data_in !== 32'h66) begin errors++; $display("FAIL rw_prestore: got %h want 66", bus.data_in); end
    @(negedge clk); bus.mem_write = 1'b0; #1;
    checks++; if (err_rw !== 1'b1) begin errors++; $display("FAIL rw_set: got %b want 1", err_rw); end
    checks++; if (bus.data_in !== 32'h77) begin errors++; $display("FAIL rw_poststore: got %h want 77", bus.data_in); end
    wait_drain("rw");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_idle();
      bus.load_valid = 1'b1; bus.load_addr = ADDR_W'(128 + i); bus.load_data = 32'hA0 + i; #1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_idle();
      bus.load_valid = 1'b1; bus.load_addr = 10'd103; bus.load_data = 32'h0;
      bus.mem_write = 1'b1; bus.data_addr = 32'h200 + 4 * i; bus.data_out = 32'hB0 + i; #1;
    end
    @(negedge clk); bus.mem_write = 1'b0; #1;
    checks++; if (wb_count !== 3'd3) begin errors++; $display("FAIL rst_mid_pre: got %0d want 3", wb_count); end
    drive_idle(); reset = 1'b1; #1;
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", wb_count); end
    checks++; if (err_misalign !== 1'b0 || err_rw !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b%b want 00", err_misalign, err_rw); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.load_ready); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_idle(); bus.mem_read = 1'b1; bus.data_addr = 32'h200 + 4 * i; #1;
      checks++; if (bus.data_in !== 32'hA0 + i) begin errors++; $display("FAIL rst_mid_word[%0d]: got %h want %h", i, bus.data_in, 32'hA0 + i); end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_loader();
    test_store_load();
    test_full_blocking();
    test_overwrite();
    test_loader_shadow();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
